// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder that sequences one external fulladder cell, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement ovf output.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    input  logic             ack,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             fa_i0,
    output logic             fa_i1,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             run;
    logic             accept;
    logic             last;

    assign run    = (state_q == S_RUN);
    assign accept = (state_q == S_IDLE) && start;
    assign last   = run && (cnt_q == LAST);

    assign ready = (state_q == S_IDLE);
    assign busy  = run;
    assign valid = (state_q == S_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

    // The cell only sees live operands while running; idle/done present zeros.
    assign fa_i0 = run & a_q[0];
    assign fa_i1 = run & b_q[0];
    assign fa_ci = run & carry_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = cnt_q;
                    cout_d  = fa_co;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // Overflow = carry into MSB xor carry out of MSB, both visible on the last bit.
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if (last) begin
            ovf_d = carry_q ^ fa_co;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ok;
    assign unused_ok = accept;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl against an arithmetic model.
// Includes a behavioural fulladder cell wired to the fa_* ports.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         ack = 1'b0;
    logic         ready, busy, valid, cout;
    logic [W-1:0] sum;
    logic         fa_i0, fa_i1, fa_ci, fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign fa_s  = fa_i0 ^ fa_i1 ^ fa_ci;
    assign fa_co = (fa_i0 & fa_i1) | (fa_ci & (fa_i0 ^ fa_i1));

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .valid (valid),
        .ack   (ack),
        .sum   (sum),
        .cout  (cout),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .fa_i0 (fa_i0),
        .fa_i1 (fa_i1),
        .fa_ci (fa_ci),
        .fa_s  (fa_s),
        .fa_co (fa_co)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic tc, input int hold, input int inj_at,
                         input int rst_at, input bit ack_start);
        logic [W:0]   ex;
        logic         ov;
        logic [2:0]   fexp;
        int           s;
        int           m;
        int           n;
        ex = (W+1)'(ta) + (W+1)'(tbv) + (W+1)'(tc);
        s  = int'(ta & 8'h7f) + int'(tbv & 8'h7f) + int'(tc);
        ov = s[W-1] ^ ex[W];
        chk("ready_pre", 64'(ready), 64'(1));
        a = ta;
        b = tbv;
        cin = tc;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
        n = 1;
        while (!valid && n <= W + 4) begin
            if (n == rst_at) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_flags", 64'({ready, busy, valid}), 64'(3'b100));
                chk("rst_sum", 64'({cout, sum}), 64'(0));
                chk("rst_fa", 64'({fa_i0, fa_i1, fa_ci}), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
                chk("rst_ovf", 64'(ovf), 64'(0));
`endif
                tick();
                rst = 1'b0;
                return;
            end
            if (n <= W) begin
                m = (1 << (n - 1)) - 1;
                s = (int'(ta) & m) + (int'(tbv) & m) + int'(tc);
                fexp = {ta[n-1], tbv[n-1], s[n-1]};
                chk("run_flags", 64'({ready, busy, valid}), 64'(3'b010));
                chk("run_fa", 64'({fa_i0, fa_i1, fa_ci}), 64'(fexp));
            end
            start = (n == inj_at);
            if (n == inj_at) a = 8'h11;
            tick();
            n++;
        end
        start = 1'b0;
        chk("latency", 64'(n), 64'(W + 1));
        chk("sum", 64'(sum), 64'(ex[W-1:0]));
        chk("cout", 64'(cout), 64'(ex[W]));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", 64'(ovf), 64'(ov));
`else
        if (ov === 1'bx) $display("note: unexpected x in overflow model");
`endif
        chk("done_flags", 64'({ready, busy, valid}), 64'(3'b001));
        chk("done_fa", 64'({fa_i0, fa_i1, fa_ci}), 64'(0));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold", 64'({valid, cout, sum}), 64'({1'b1, ex}));
        end
        ack = 1'b1;
        if (ack_start) begin
            start = 1'b1;
            a = 8'h11;
        end
        tick();
        ack = 1'b0;
        start = 1'b0;
        chk("idle_flags", 64'({ready, busy, valid}), 64'(3'b100));
        chk("idle_fa", 64'({fa_i0, fa_i1, fa_ci}), 64'(0));
        if (ack_start) begin
            tick();
            chk("no_accept", 64'({ready, busy}), 64'(2'b10));
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        tick();
        tick();
        chk("reset_flags", 64'({ready, busy, valid}), 64'(3'b100));
        chk("reset_sum", 64'({cout, sum}), 64'(0));
        chk("reset_fa", 64'({fa_i0, fa_i1, fa_ci}), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
        chk("reset_ovf", 64'(ovf), 64'(0));
`endif
        rst = 1'b0;
        tick();

        do_op(8'h5A, 8'h3C, 1'b0, 0, 0, 0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 0, 0, 0, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 0, 0, 0, 1'b0);
        do_op(8'h5A, 8'h3C, 1'b0, 0, 3, 0, 1'b0);
        do_op(8'hAA, 8'h55, 1'b0, 0, 0, 4, 1'b0);
        do_op(8'h01, 8'h02, 1'b0, 0, 0, 0, 1'b0);
        do_op(8'hC3, 8'h7E, 1'b1, 5, 0, 0, 1'b1);
        do_op(8'h80, 8'h80, 1'b0, 0, 0, 0, 1'b0);
        do_op(8'h7F, 8'h00, 1'b1, 0, 0, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), 0, 0, 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
